// File: rtl/ysyx_22050243_lsu_pkg.sv
// Shared types and constants for the ysyx_22050243 load/store unit.
package ysyx_22050243_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // funct3 width/sign codes shared by loads and stores (stores use [1:0] only)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam int MASK_W = 8;

endpackage

// File: rtl/ysyx_22050243_lsu_if.sv
// Data-memory request/response port between the LSU (master) and memory (slave).
interface ysyx_22050243_lsu_if
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wen;
    logic [XLEN-1:0]   mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [XLEN-1:0]   mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational byte-lane logic: store strobes/shift, load extract/extend, misalign detect.
// Misalign detection is built only when YSYX_22050243_LSU_MISALIGN_CHECK_EN is defined.
module ysyx_22050243_lsu_align
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        off,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    input  logic [2:0]        chk_off,
    input  logic [2:0]        chk_funct3,
    output logic [MASK_W-1:0] wmask,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   load_data,
    output logic              misalign
);
    logic [XLEN-1:0] rdata_sh;

    // Strobes shift within 8 bits, so lanes past the dword fall off the top.
    always_comb begin
        wmask = '0;
        case (funct3[1:0])
            2'b00:   wmask = 8'h01 << off;
            2'b01:   wmask = 8'h03 << off;
            2'b10:   wmask = 8'h0F << off;
            default: wmask = 8'hFF;
        endcase
    end

    assign wdata_sh = wdata << {off, 3'b000};
    assign rdata_sh = rdata >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        case (funct3)
            LB:      load_data = {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
            LH:      load_data = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            LW:      load_data = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
            LD:      load_data = rdata_sh;
            LBU:     load_data = {{(XLEN-8){1'b0}}, rdata_sh[7:0]};
            LHU:     load_data = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
            LWU:     load_data = {{(XLEN-32){1'b0}}, rdata_sh[31:0]};
            default: load_data = '0;
        endcase
    end

`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (chk_funct3[1:0])
            2'b01:   misalign = chk_off[0];
            2'b10:   misalign = |chk_off[1:0];
            2'b11:   misalign = |chk_off;
            default: misalign = 1'b0;
        endcase
    end
`else
    logic unused_chk;
    assign unused_chk = ^{chk_off, chk_funct3};
    assign misalign   = 1'b0;
`endif

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Multi-cycle load/store unit: one accepted op becomes one valid/ready memory transaction.
// Optional misalign trapping is enabled by YSYX_22050243_LSU_MISALIGN_CHECK_EN.
module ysyx_22050243_lsu
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mem_r,
    input  logic                       in_mem_w,
    input  logic [2:0]                 in_funct3,
    input  logic [XLEN-1:0]            in_addr,
    input  logic [XLEN-1:0]            in_wdata,
    ysyx_22050243_lsu_if.master        mem,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_rdata,
    output logic                       out_misalign
);
    lsu_state_t        state;
    lsu_state_t        state_nxt;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic [2:0]        funct3_q;
    logic              wen_q;
    logic              misalign_q;
    logic [MASK_W-1:0] wmask;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   load_data;
    logic              misalign;
    logic              accept;
    logic              is_mem;
    logic              in_req;

    assign accept = (state == IDLE) && in_valid;
    assign is_mem = in_mem_r | in_mem_w;

    ysyx_22050243_lsu_align #(.XLEN(XLEN)) u_align (
        .off        (addr_q[2:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .rdata      (mem.mem_resp_rdata),
        .chk_off    (in_addr[2:0]),
        .chk_funct3 (in_funct3),
        .wmask      (wmask),
        .wdata_sh   (wdata_sh),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults come first in every combinational block so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (is_mem && !misalign) ? REQ : DONE;
            REQ:  if (mem.mem_req_ready) state_nxt = RESP;
            RESP: if (mem.mem_resp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captured op fields and the result register; a new accept clears any stale result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            wen_q      <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            funct3_q   <= in_funct3;
            wen_q      <= in_mem_w;
            rdata_q    <= '0;
            misalign_q <= misalign && is_mem;
        end else if (state == RESP && mem.mem_resp_valid) begin
            rdata_q    <= wen_q ? '0 : load_data;
        end
    end

    assign in_req = (state == REQ);

    always_comb begin
        in_ready           = (state == IDLE);
        mem.mem_req_valid  = in_req;
        mem.mem_req_wen    = in_req && wen_q;
        mem.mem_req_addr   = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
        mem.mem_req_wdata  = in_req ? wdata_sh : '0;
        mem.mem_req_wmask  = (in_req && wen_q) ? wmask : '0;
        mem.mem_resp_ready = (state == RESP);
        out_valid          = (state == DONE);
        out_rdata          = rdata_q;
        out_misalign       = misalign_q;
    end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Scoreboard bench for ysyx_22050243_lsu: directed ops, expected requests/results queued and
// compared by independent monitors on the memory port and the writeback port.
module tb_ysyx_22050243_lsu;
    import ysyx_22050243_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_mem_r;
    logic            in_mem_w;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic            out_misalign;

    ysyx_22050243_lsu_if #(.XLEN(XLEN)) mem_bus ();

    ysyx_22050243_lsu #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mem_r     (in_mem_r),
        .in_mem_w     (in_mem_w),
        .in_funct3    (in_funct3),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .mem          (mem_bus.master),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          cycles;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        misalign;
        int          lat;
        int          cycles;
    } res_t;

    req_t        exp_req[$];
    res_t        exp_res[$];
    logic [63:0] mem_data_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_accept = 0;
    int req_stall = 0;
    int out_stall = 0;
    bit resp_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m, input int c);
        req_t r;
        r.wen = w; r.addr = a; r.wdata = d; r.wmask = m; r.cycles = c;
        exp_req.push_back(r);
    endtask

    task automatic push_res(input logic [63:0] d, input logic mis, input int lat, input int c);
        res_t r;
        r.rdata = d; r.misalign = mis; r.lat = lat; r.cycles = c;
        exp_res.push_back(r);
    endtask

    // Memory model: ready unless stalled, answers one cycle after each request handshake.
    initial begin : mem_model
        bit req_hs, resp_hs, rst_act, stall_hit;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            req_hs    = mem_bus.mem_req_valid && mem_bus.mem_req_ready;
            resp_hs   = mem_bus.mem_resp_valid && mem_bus.mem_resp_ready;
            stall_hit = mem_bus.mem_req_valid && !mem_bus.mem_req_ready;
            rst_act   = !rst_n;
            @(posedge clk);
            #1;
            if (rst_act) begin
                mem_bus.mem_resp_valid = 1'b0;
                mem_bus.mem_resp_rdata = '0;
            end else begin
                if (resp_hs) mem_bus.mem_resp_valid = 1'b0;
                if (req_hs) begin
                    mem_bus.mem_resp_rdata = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : '0;
                    if (!resp_hold) mem_bus.mem_resp_valid = 1'b1;
                end
                if (stall_hit && req_stall > 0) req_stall--;
            end
            mem_bus.mem_req_ready = (req_stall == 0);
        end
    end

    // Writeback model: takes the result unless told to hold off.
    initial begin : wbu_model
        bit hit;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            hit = out_valid && !out_ready;
            @(posedge clk);
            #1;
            if (hit && out_stall > 0) out_stall--;
            out_ready = (out_stall == 0);
        end
    end

    initial begin : req_monitor
        req_t er;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req_valid) begin
                if (exp_req.size() == 0) begin
                    fail("req_unexpected");
                end else begin
                    er = exp_req[0];
                    check("req_wen", mem_bus.mem_req_wen, er.wen);
                    check("req_addr", mem_bus.mem_req_addr, er.addr);
                    check("req_wdata", mem_bus.mem_req_wdata, er.wdata);
                    check("req_wmask", mem_bus.mem_req_wmask, er.wmask);
                    n++;
                    if (mem_bus.mem_req_ready) begin
                        if (er.cycles != 0) check("req_valid_cycles", n, er.cycles);
                        void'(exp_req.pop_front());
                        n = 0;
                    end
                end
            end
        end
    end

    initial begin : res_monitor
        res_t er;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("in_ready_while_done", in_ready, 1'b0);
                if (exp_res.size() == 0) begin
                    fail("result_unexpected");
                end else begin
                    er = exp_res[0];
                    if (n == 0 && er.lat != 0) check("result_latency", cyc - last_accept, er.lat);
                    check("out_rdata", out_rdata, er.rdata);
                    check("out_misalign", out_misalign, er.misalign);
                    n++;
                    if (out_ready) begin
                        if (er.cycles != 0) check("out_valid_cycles", n, er.cycles);
                        void'(exp_res.pop_front());
                        n = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] d);
        bit acc;
        int n;
        n = 0;
        in_mem_r = r; in_mem_w = w; in_funct3 = f3; in_addr = a; in_wdata = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) last_accept = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) fail("accept_timeout");
        in_valid = 1'b0; in_mem_r = 1'b0; in_mem_w = 1'b0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_res.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rd,
                            input logic [63:0] exp_data);
        push_req(1'b0, {a[63:3], 3'b000}, 64'h0, 8'h00, 0);
        mem_data_q.push_back(rd);
        push_res(exp_data, 1'b0, 3, 0);
        issue(1'b1, 1'b0, f3, a, 64'h0);
        wait_idle();
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                             input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
        push_req(1'b1, {a[63:3], 3'b000}, exp_wdata, exp_mask, 0);
        mem_data_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
        push_res(64'h0, 1'b0, 3, 0);
        issue(1'b0, 1'b1, f3, a, d);
        wait_idle();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_req_valid"}, mem_bus.mem_req_valid, 1'b0);
        check({tag, "_req_wen"}, mem_bus.mem_req_wen, 1'b0);
        check({tag, "_req_addr"}, mem_bus.mem_req_addr, 64'h0);
        check({tag, "_req_wdata"}, mem_bus.mem_req_wdata, 64'h0);
        check({tag, "_req_wmask"}, mem_bus.mem_req_wmask, 8'h00);
        check({tag, "_resp_ready"}, mem_bus.mem_resp_ready, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_rdata"}, out_rdata, 64'h0);
        check({tag, "_out_misalign"}, out_misalign, 1'b0);
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        in_valid = 1'b0; in_mem_r = 1'b0; in_mem_w = 1'b0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_quiet("reset");
        @(posedge clk);
        #1;

        // sb: byte lane 3, minimum latency
        run_store(LB, 64'h8000_0003, 64'hAB, 64'h0000_0000_AB00_0000, 8'h08);
        // lb / lbu / funct3 111 on byte lane 5
        run_load(LB, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load(LBU, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080);
        run_load(3'b111, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'h0);
        // halfword/word extensions and wider stores
        run_load(LH, 64'h8000_0002, 64'h0000_0000_ABCD_0000, 64'hFFFF_FFFF_FFFF_ABCD);
        run_load(LHU, 64'h8000_0002, 64'h0000_0000_ABCD_0000, 64'h0000_0000_0000_ABCD);
        run_load(LWU, 64'h8000_0004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
        run_store(LW, 64'h8000_0004, 64'hCAFE_BABE, 64'hCAFE_BABE_0000_0000, 8'hF0);
        run_store(LD, 64'h8000_0018, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'hFF);

        // lw with request stalled 3 cycles: valid held 4 cycles, one handshake
        req_stall = 3;
        @(posedge clk);
        #1;
        push_req(1'b0, 64'h8000_0010, 64'h0, 8'h00, 4);
        mem_data_q.push_back(64'h1234_5678_8765_4321);
        push_res(64'hFFFF_FFFF_8765_4321, 1'b0, 0, 0);
        issue(1'b1, 1'b0, LW, 64'h8000_0010, 64'h0);
        wait_idle();

        // ld with writeback stalled 5 cycles while the next op (sh) waits on in_valid
        out_stall = 5;
        @(posedge clk);
        #1;
        push_req(1'b0, 64'h8000_0008, 64'h0, 8'h00, 0);
        mem_data_q.push_back(64'h0123_4567_89AB_CDEF);
        push_res(64'h0123_4567_89AB_CDEF, 1'b0, 3, 6);
        issue(1'b1, 1'b0, LD, 64'h8000_0008, 64'h0);
        push_req(1'b1, 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 0);
        mem_data_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
        push_res(64'h0, 1'b0, 0, 0);
        issue(1'b0, 1'b1, LH, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
        wait_idle();

        // non-memory op goes straight to DONE; store wins when both flags are set
        push_res(64'h0, 1'b0, 1, 0);
        issue(1'b0, 1'b0, LD, 64'h8000_0000, 64'h99);
        wait_idle();
        push_req(1'b1, 64'h8000_0000, 64'h55, 8'h0F, 0);
        mem_data_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        push_res(64'h0, 1'b0, 3, 0);
        issue(1'b1, 1'b1, LW, 64'h8000_0000, 64'h55);
        wait_idle();

        // reset while waiting in RESP, then a late response pulse that must be ignored
        resp_hold = 1'b1;
        push_req(1'b0, 64'h8000_0020, 64'h0, 8'h00, 0);
        mem_data_q.push_back(64'h1111_2222_3333_4444);
        issue(1'b1, 1'b0, LW, 64'h8000_0020, 64'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("resp_ready_in_resp", mem_bus.mem_resp_ready, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("midreset");
        rst_n = 1'b1;
        resp_hold = 1'b0;
        mem_bus.mem_resp_rdata = 64'h5555_5555_5555_5555;
        mem_bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        check("late_resp_ready", mem_bus.mem_resp_ready, 1'b0);
        @(posedge clk);
        #1;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;
        @(posedge clk);
        #1;
        check("late_resp_out_valid", out_valid, 1'b0);
        check("late_resp_out_rdata", out_rdata, 64'h0);
        run_load(LW, 64'h8000_0020, 64'h0000_0000_7654_3210, 64'h0000_0000_7654_3210);

        // misaligned word load and store
`ifdef YSYX_22050243_LSU_MISALIGN_CHECK_EN
        push_res(64'h0, 1'b1, 1, 0);
        issue(1'b1, 1'b0, LW, 64'h8000_0002, 64'h0);
        wait_idle();
        push_res(64'h0, 1'b1, 1, 0);
        issue(1'b0, 1'b1, LW, 64'h8000_0006, 64'hAABB_CCDD);
        wait_idle();
`else
        run_load(LW, 64'h8000_0002, 64'h0000_9ABC_DEF0_1234, 64'hFFFF_FFFF_9ABC_DEF0);
        run_store(LW, 64'h8000_0006, 64'hAABB_CCDD, 64'hCCDD_0000_0000_0000, 8'hC0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("pending_requests", exp_req.size(), 0);
        check("pending_results", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050243_lsu.md
Name: ysyx_22050243_lsu

Overview:
Multi-cycle load/store unit consuming the decoder's mem_r/mem_w/funct3 controls at the far end of the EXU→MEM path. It turns one accepted memory op into a single valid/ready transaction on a 64-bit data-memory port. Stores get byte-lane alignment and strobe generation. Load responses are lane-extracted and sign/zero-extended before being handed to writeback.

Parameters:
XLEN, 64, data/address width; fixed at 64 for RV64, parameterised for width checks only.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  EXU presents an op
in_ready  out  1  LSU can accept (IDLE only)
in_mem_r  in  1  load op
in_mem_w  in  1  store op
in_funct3  in  3  width/sign code
in_addr  in  XLEN  effective address (ALU result)
in_wdata  in  XLEN  store data (rs2)
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1=store, 0=load
mem_req_addr  out  XLEN  in_addr with bits[2:0] cleared
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  8  byte strobes (0 on loads)
mem_resp_valid  in  1  response valid
mem_resp_ready  out  1  LSU accepts response
mem_resp_rdata  in  XLEN  aligned 64-bit read data
out_valid  out  1  result ready for WBU
out_ready  in  1  WBU takes result
out_rdata  out  XLEN  extended load data (0 for stores/non-mem)
out_misalign  out  1  misaligned-access flag

Behaviour:
- Reset (rst_n low at posedge): state IDLE; every output 0 except in_ready=1 on the first cycle after release.
- States: IDLE, REQ, RESP, DONE. All outputs come from registers or decode of state plus captured fields, never combinationally from in_* ports.
- IDLE: in_ready=1. On in_valid, capture addr/funct3/wdata/op.
  - mem_w set → REQ with wen=1 (mem_w wins if both mem_r and mem_w are set).
  - Only mem_r set → REQ with wen=0.
  - Neither set → DONE with out_rdata=0.
- REQ: mem_req_valid=1; addr/wdata/wmask/wen held stable until mem_req_ready; then → RESP.
- RESP: mem_resp_ready=1. On mem_resp_valid, register the extended data (stores: out_rdata=0) → DONE. A response is accepted in RESP only; responses in any other state are ignored.
- DONE: out_valid=1; on out_ready → IDLE. No back-to-back accept: in_ready is 1 in IDLE only.
- Minimum latency: accept at cycle 0, out_valid at cycle 3 when req_ready and resp_valid are both high on first assertion.
- Store mask by funct3[1:0], with off = addr[2:0]:
  - 00: 0x01<<off
  - 01: 0x03<<off
  - 10: 0x0F<<off
  - 11: 0xFF
  - Result truncated to 8 bits.
  - wdata is shifted left by off*8, truncated to 64 bits.
- Load extract: rdata shifted right by off*8, then by funct3:
  - 000 sign-extend 8 bits; 001 sign-extend 16; 010 sign-extend 32; 011 full 64.
  - 100 zero-extend 8; 101 zero-extend 16; 110 zero-extend 32; 111 result 0.
- Reset mid-transaction: the op is abandoned. mem_req_valid/mem_resp_ready/out_valid are 0 after the reset edge. The memory side resets on the same rst_n.

Optional Feature:
Macro YSYX_22050243_LSU_MISALIGN_CHECK_EN.
- Defined: an access is misaligned when halfword with off[0]≠0, word with off[1:0]≠0, or dword with off≠0. A misaligned op issues no memory request: IDLE → DONE with out_misalign=1 and out_rdata=0.
- Undefined: out_misalign tied 0. Misaligned ops issue normally with truncated mask; bytes beyond the dword are dropped.

Decomposition:
- Package ysyx_22050243_pkg holds:
  - the lsu_state_t enum (IDLE/REQ/RESP/DONE);
  - funct3 width constants (LB, LH, LW, LD, LBU, LHU, LWU);
  - a mask-width localparam.
- Sub-module ysyx_22050243_lsu_align is purely combinational: mask, wdata shift, load extract/extend, misalign detect. The FSM lives in the top module.

Test Plan:
- sb addr 0x8000_0003, wdata 0xAB, req_ready=1 → mem_req_addr 0x8000_0000, wmask 0x08, wdata 0x0000_0000_AB00_0000, wen=1; out_valid at cycle 3 with out_rdata 0.
- lb addr 0x8000_0005, resp_rdata 0x0000_8000_0000_0000 → out_rdata 0xFFFF_FFFF_FFFF_FF80. Same with lbu → 0x80. Same with funct3 111 → 0.
- lw with mem_req_ready low for 3 cycles → mem_req_valid stays 1 and addr/wmask stable for 4 cycles; one request handshake only.
- out_ready held low 5 cycles in DONE → out_valid and out_rdata held, in_ready 0, in_valid ignored; single result delivered.
- rst_n low during RESP, then mem_resp_valid pulses after release → all outputs 0 after reset edge; late response not accepted; next op completes normally.
- Macro on: lw addr 0x8000_0002 → no mem_req_valid; out_valid and out_misalign=1 one cycle after accept. Macro off: same op issues with wmask 0 (load) and completes.
